// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, Diff = A - B, LSB first.
// One bit operation per clock with a registered borrow, Start/Busy/Done handshake.
// Ports:
//   Clk     rising-edge clock
//   Rst_n   synchronous active-low reset
//   Start   request, sampled only while idle
//   A, B    minuend / subtrahend, captured on the accepting edge
//   Busy    high while bit operations are in progress
//   Done    one-cycle pulse, Diff/Borrow valid from this cycle
//   Diff    (A - B) mod 2^WIDTH, held until the next completed transaction
//   Borrow  1 iff A < B (unsigned)
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sd_q, sd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bw_q, bw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic bit_a, bit_b, bit_d;

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        sd_d     = sd_q;
        cnt_d    = cnt_q;
        bw_d     = bw_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bit_a    = sa_q[0];
        bit_b    = sb_q[0];
        bit_d    = bit_a ^ bit_b ^ bw_q;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    sa_d    = A;
                    sb_d    = B;
                    sd_d    = '0;
                    cnt_d   = '0;
                    bw_d    = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Borrow out of one full-subtractor cell
                bw_d  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & bw_q);
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sd_d  = {bit_d, sd_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Final bit: publish the fully shifted result
                    diff_d   = sd_d;
                    borrow_d = bw_d;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q  <= ST_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            sd_q     <= '0;
            cnt_q    <= '0;
            bw_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sd_q     <= sd_d;
            cnt_q    <= cnt_d;
            bw_q     <= bw_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    // Decodes of the state register only; no input-to-output path
    assign Busy   = (state_q == ST_RUN);
    assign Done   = (state_q == ST_DONE);
    assign Diff   = diff_q;
    assign Borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=4 and WIDTH=8 instances, exact
// cycle-by-cycle handshake checks plus hand-computed results.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start4, start8;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic       busy4, done4, borrow4;
    logic       busy8, done8, borrow8;
    logic [3:0] diff4;
    logic [7:0] diff8;

    int checks = 0;
    int errors = 0;

    logic [3:0] prev_diff4;
    logic       prev_borrow4;

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .Clk    (clk),
        .Rst_n  (rst_n),
        .Start  (start4),
        .A      (a4),
        .B      (b4),
        .Busy   (busy4),
        .Done   (done4),
        .Diff   (diff4),
        .Borrow (borrow4)
    );

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .Clk    (clk),
        .Rst_n  (rst_n),
        .Start  (start8),
        .A      (a8),
        .B      (b8),
        .Busy   (busy8),
        .Done   (done8),
        .Diff   (diff8),
        .Borrow (borrow8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge; inputs are driven and outputs sampled here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=4 transaction with a full handshake timing check
    task automatic do4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] exp_diff, input logic exp_borrow);
        a4 = a;
        b4 = b;
        start4 = 1'b1;
        tick();  // E0: accepted
        start4 = 1'b0;
        check("acc_busy", busy4, 1'b1);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("run_busy", busy4, 1'b1);
            check("run_done", done4, 1'b0);
            check("run_hold_diff", diff4, prev_diff4);
            check("run_hold_borrow", borrow4, prev_borrow4);
        end
        tick();  // E4
        check("done_pulse", done4, 1'b1);
        check("done_busy", busy4, 1'b0);
        check("diff4", diff4, exp_diff);
        check("borrow4", borrow4, exp_borrow);
        tick();  // E5
        check("done_width", done4, 1'b0);
        check("idle_busy", busy4, 1'b0);
        check("diff4_hold", diff4, exp_diff);
        prev_diff4   = exp_diff;
        prev_borrow4 = exp_borrow;
    endtask

    task automatic do8(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_diff, input logic exp_borrow);
        a8 = a;
        b8 = b;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            check("run8_busy", busy8, 1'b1);
            check("run8_done", done8, 1'b0);
        end
        tick();  // E8
        check("done8_pulse", done8, 1'b1);
        check("diff8", diff8, exp_diff);
        check("borrow8", borrow8, exp_borrow);
        tick();
        check("done8_width", done8, 1'b0);
    endtask

    initial begin
        rst_n  = 1'b0;
        start4 = 1'b0;
        start8 = 1'b0;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0;
        prev_diff4   = '0;
        prev_borrow4 = 1'b0;
        tick();
        tick();
        check("rst_busy", busy4, 1'b0);
        check("rst_done", done4, 1'b0);
        check("rst_diff", diff4, 4'd0);
        check("rst_borrow", borrow4, 1'b0);
        check("rst_diff8", diff8, 8'd0);
        rst_n = 1'b1;
        tick();
        check("idle_no_start", busy4, 1'b0);

        // Directed basics
        do4(4'd5, 4'd3, 4'd2, 1'b0);
        do4(4'd3, 4'd5, 4'd14, 1'b1);
        do4(4'd0, 4'd15, 4'd1, 1'b1);
        do4(4'd15, 4'd0, 4'd15, 1'b0);
        do4(4'd7, 4'd7, 4'd0, 1'b0);

        // Full sweep against a modular-arithmetic model
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                logic [3:0] ea;
                logic [3:0] eb;
                ea = 4'(i);
                eb = 4'(j);
                do4(ea, eb, ea - eb, (i < j) ? 1'b1 : 1'b0);
            end
        end

        // Start held high; operands change during RUN
        a4 = 4'd7;
        b4 = 4'd2;
        start4 = 1'b1;
        tick();  // E0
        a4 = 4'd1;
        b4 = 4'd9;
        check("held_acc_busy", busy4, 1'b1);
        tick(); tick(); tick();
        check("held_run_busy", busy4, 1'b1);
        tick();  // E4
        check("held_done", done4, 1'b1);
        check("held_diff", diff4, 4'd5);
        check("held_borrow", borrow4, 1'b0);
        tick();  // E5: DONE -> IDLE, Start ignored
        check("held_ignored", busy4, 1'b0);
        tick();  // E6: reaccepted with 1,9
        check("held_reaccept", busy4, 1'b1);
        start4 = 1'b0;
        tick(); tick(); tick(); tick();  // E10
        check("held2_done", done4, 1'b1);
        check("held2_diff", diff4, 4'd8);
        check("held2_borrow", borrow4, 1'b1);
        tick();
        prev_diff4   = 4'd8;
        prev_borrow4 = 1'b1;

        // Reset mid-RUN after two bit operations
        a4 = 4'd12;
        b4 = 4'd3;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_busy", busy4, 1'b0);
        check("mrst_done", done4, 1'b0);
        check("mrst_diff", diff4, 4'd0);
        check("mrst_borrow", borrow4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mrst_no_done", done4, 1'b0);
        end
        prev_diff4   = '0;
        prev_borrow4 = 1'b0;
        do4(4'd9, 4'd4, 4'd5, 1'b0);

        // WIDTH=8 instance
        do8(8'h00, 8'h01, 8'hFF, 1'b1);
        do8(8'hA5, 8'hA5, 8'h00, 1'b0);
        do8(8'hC8, 8'h37, 8'h91, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
